// File: rtl/hit_sensor_if.sv
// Sensor-side bundle for the hit conditioner: game qualifier and raw strike
// lines in, clean hit event and status out.
interface hit_sensor_if;
  logic       enable;
  logic [2:0] GPIO_1;
  logic       hit_valid;
  logic [2:0] hit_box;
  logic       multi_hit;
  logic [2:0] sensor_level;
  logic [7:0] hit_count;
  logic       busy;

  // Conditioner side: consumes sensor lines, produces hit events.
  modport slave (
    input  enable, GPIO_1,
    output hit_valid, hit_box, multi_hit, sensor_level, hit_count, busy
  );

  // Stimulus / consumer side.
  modport master (
    output enable, GPIO_1,
    input  hit_valid, hit_box, multi_hit, sensor_level, hit_count, busy
  );
endinterface

// File: rtl/hit_sensor_conditioner.sv
// Synchronises, debounces and arbitrates three hit sensors, then emits one
// single-cycle hit event per strike with lockout and release re-arm.
module hit_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LOCKOUT_CYCLES  = 2500000,
  parameter int CNT_W           = 22
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  hit_sensor_if.slave bus
);

  typedef enum logic [1:0] {WAIT_RELEASE, ARMED, LOCKOUT} state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

  logic [2:0]       sync1, sync2;
  logic [2:0]       level;
  logic [CNT_W-1:0] db_cnt [3];
  logic [CNT_W-1:0] lock_cnt;
  state_t           state, next_state;
  logic             fire, multi;
  logic [2:0]       box_code;
  logic             hit_valid_q, multi_q, busy_q;
  logic [2:0]       hit_box_q;
  logic [7:0]       hit_count_q;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.GPIO_1;
      sync2 <= sync1;
    end
  end

  // NOTE: the per-line counters are a small flop array, not RAM, so they are
  // reset like any other register to abort a debounce in progress.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      level <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            level[i]  <= ~level[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CNT_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= WAIT_RELEASE;
    else         state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      WAIT_RELEASE: if (level == 3'b000 && bus.enable) next_state = ARMED;
      ARMED: begin
        if (!bus.enable)  next_state = WAIT_RELEASE;
        else if (|level)  next_state = LOCKOUT;
      end
      LOCKOUT: if (!bus.enable || lock_cnt == LK_LAST) next_state = WAIT_RELEASE;
      default: next_state = WAIT_RELEASE;
    endcase
  end

  always_comb begin
    fire     = (state == ARMED) && bus.enable && (|level);
    multi    = ($countones(level) > 1);
    box_code = 3'd0;
    if (level[0])      box_code = 3'd1;
    else if (level[1]) box_code = 3'd2;
    else if (level[2]) box_code = 3'd3;
  end

  // Counter is held at zero outside LOCKOUT so every lockout starts fresh.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)                lock_cnt <= '0;
    else if (state == LOCKOUT)  lock_cnt <= lock_cnt + CNT_W'(1);
    else                        lock_cnt <= '0;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      hit_valid_q <= 1'b0;
      multi_q     <= 1'b0;
      busy_q      <= 1'b0;
      hit_box_q   <= 3'd0;
      hit_count_q <= 8'd0;
    end else begin
      hit_valid_q <= fire;
      multi_q     <= fire && multi;
      busy_q      <= (next_state != ARMED);
      if (fire) begin
        hit_box_q <= box_code;
        if (hit_count_q != 8'hFF) hit_count_q <= hit_count_q + 8'd1;
      end
    end
  end

  assign bus.hit_valid    = hit_valid_q;
  assign bus.hit_box      = hit_box_q;
  assign bus.multi_hit    = multi_q;
  assign bus.sensor_level = level;
  assign bus.hit_count    = hit_count_q;
  assign bus.busy         = busy_q;

endmodule
